// File: rtl/mem_write_checker.sv
// mem_write_checker: self-check monitor for data-memory store channels.
// Watches NUM_CH store channels and finishes a run in PASS, FAIL or (when
// MEM_WRITE_CHECKER_TIMEOUT_EN is defined) TIMEOUT, capturing fail details
// and counting legal stores to ALLOW_ADDR.
module mem_write_checker #(
  parameter int                 ADDR_W     = 32,
  parameter int                 DATA_W     = 32,
  parameter int                 NUM_CH     = 1,
  parameter logic [ADDR_W-1:0]  PASS_ADDR  = 100,
  parameter logic [DATA_W-1:0]  PASS_DATA  = 7,
  parameter logic [ADDR_W-1:0]  ALLOW_ADDR = 96,
  parameter int                 TIMEOUT    = 1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     arm,
  input  logic                     clr,
  input  logic [NUM_CH-1:0]        mem_write,
  input  logic [NUM_CH*ADDR_W-1:0] data_adr,
  input  logic [NUM_CH*DATA_W-1:0] write_data,
  output logic                     done,
  output logic                     pass,
  output logic [1:0]               fail_code,
  output logic [1:0]               fail_ch,
  output logic [ADDR_W-1:0]        fail_addr,
  output logic [DATA_W-1:0]        fail_data,
  output logic [15:0]              store_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
    , S_TIMEOUT
`endif
  } state_t;

  state_t state, state_nxt;

  logic              any_fail, any_good;
  logic [1:0]        first_ch, first_code;
  logic [ADDR_W-1:0] first_addr, ch_addr;
  logic [DATA_W-1:0] first_data, ch_data;
  logic [2:0]        legal_n;
  logic [16:0]       count_sum;
  logic [15:0]       count_nxt;
  logic              timeout_hit;

`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] run_cnt;

  // Timeout fires on the edge where the run counter has reached its last value
  always_comb timeout_hit = (run_cnt == CNT_W'(TIMEOUT - 1));
`else
  // Without the timeout option a run never expires on its own
  always_comb timeout_hit = 1'b0;
`endif

  // Classify every active channel; scanning downward leaves the lowest failing index captured
  always_comb begin
    any_fail   = 1'b0;
    any_good   = 1'b0;
    first_ch   = '0;
    first_code = '0;
    first_addr = '0;
    first_data = '0;
    legal_n    = '0;
    ch_addr    = '0;
    ch_data    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      ch_addr = data_adr[i*ADDR_W +: ADDR_W];
      ch_data = write_data[i*DATA_W +: DATA_W];
      if (mem_write[i]) begin
        if (ch_addr == PASS_ADDR) begin
          if (ch_data == PASS_DATA) begin
            any_good = 1'b1;
          end else begin
            any_fail   = 1'b1;
            first_ch   = 2'(i);
            first_code = 2'b10;
            first_addr = ch_addr;
            first_data = ch_data;
          end
        end else if (ch_addr == ALLOW_ADDR) begin
          legal_n = legal_n + 3'd1;
        end else begin
          any_fail   = 1'b1;
          first_ch   = 2'(i);
          first_code = 2'b01;
          first_addr = ch_addr;
          first_data = ch_data;
        end
      end
    end
  end

  // Saturating legal-store count including every legal channel this cycle
  always_comb begin
    count_sum = {1'b0, store_count} + 17'(legal_n);
    count_nxt = count_sum[16] ? 16'hFFFF : count_sum[15:0];
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: clr wins, then failures, then pass, then timeout
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (arm) state_nxt = S_RUN;
        S_RUN: begin
          if (any_fail)      state_nxt = S_FAIL;
          else if (any_good) state_nxt = S_PASS;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
          else if (timeout_hit) state_nxt = S_TIMEOUT;
`endif
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Status outputs decoded from the state register only
  always_comb begin
    pass = (state == S_PASS);
    done = (state == S_PASS) || (state == S_FAIL)
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
           || (state == S_TIMEOUT)
`endif
           ;
  end

  // Result capture and counters; terminal states freeze everything until clr
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fail_code   <= '0;
      fail_ch     <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
      store_count <= '0;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
      run_cnt     <= '0;
`endif
    end else if (clr || (state == S_IDLE && arm)) begin
      fail_code   <= '0;
      fail_ch     <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
      store_count <= '0;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
      run_cnt     <= '0;
`endif
    end else if (state == S_RUN) begin
      store_count <= count_nxt;
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
      run_cnt     <= run_cnt + 1'b1;
`endif
      if (any_fail) begin
        fail_code <= first_code;
        fail_ch   <= first_ch;
        fail_addr <= first_addr;
        fail_data <= first_data;
      end else if (!any_good && timeout_hit) begin
        fail_code <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed self-checking bench for mem_write_checker with two store channels
// and TIMEOUT=10; timeout expectations follow MEM_WRITE_CHECKER_TIMEOUT_EN.
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm, clr;
  logic [1:0]  mem_write;
  logic [63:0] data_adr, write_data;
  logic        done, pass;
  logic [1:0]  fail_code, fail_ch;
  logic [31:0] fail_addr, fail_data;
  logic [15:0] store_count;

  int compared = 0;
  int mismatched = 0;

  mem_write_checker #(
    .ADDR_W(32), .DATA_W(32), .NUM_CH(2),
    .PASS_ADDR(32'd100), .PASS_DATA(32'd7), .ALLOW_ADDR(32'd96),
    .TIMEOUT(10)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .clr(clr),
    .mem_write(mem_write), .data_adr(data_adr), .write_data(write_data),
    .done(done), .pass(pass), .fail_code(fail_code), .fail_ch(fail_ch),
    .fail_addr(fail_addr), .fail_data(fail_data), .store_count(store_count)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] we, input logic [31:0] a0, input logic [31:0] d0,
                               input logic [31:0] a1, input logic [31:0] d1);
    mem_write  = we;
    data_adr   = {a1, a0};
    write_data = {d1, d0};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic d, input logic p, input logic [1:0] code,
                          input logic [1:0] ch, input logic [31:0] addr, input logic [31:0] data,
                          input logic [15:0] cnt);
    checkOutput({tag, ".done"},  32'(done),        32'(d));
    checkOutput({tag, ".pass"},  32'(pass),        32'(p));
    checkOutput({tag, ".code"},  32'(fail_code),   32'(code));
    checkOutput({tag, ".ch"},    32'(fail_ch),     32'(ch));
    checkOutput({tag, ".addr"},  fail_addr,        addr);
    checkOutput({tag, ".data"},  fail_data,        data);
    checkOutput({tag, ".count"}, 32'(store_count), 32'(cnt));
  endtask

  task automatic idle();
    applyStimulus(2'b00, 0, 0, 0, 0);
  endtask

  task automatic doClear();
    idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic doArm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; clr = 1'b0;
    idle();
    tick(); tick();
    checkAll("reset", 0, 0, 2'b00, 2'b00, 0, 0, 0);
    reset = 1'b1;
    tick();

    // Stores in IDLE and on the arm edge are ignored
    applyStimulus(2'b01, 104, 0, 0, 0);
    tick();
    checkAll("idle_store", 0, 0, 2'b00, 2'b00, 0, 0, 0);
    doArm();
    checkAll("arm_edge_store", 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // Two legal stores then the pass store
    applyStimulus(2'b01, 96, 3, 0, 0);  tick();
    checkOutput("cnt1", 32'(store_count), 1);
    applyStimulus(2'b01, 96, 5, 0, 0);  tick();
    checkOutput("cnt2", 32'(store_count), 2);
    applyStimulus(2'b01, 100, 7, 0, 0); tick();
    checkAll("pass_run", 1, 1, 2'b00, 2'b00, 0, 0, 2);
    applyStimulus(2'b11, 104, 1, 96, 1); tick();
    checkAll("stray_after_pass", 1, 1, 2'b00, 2'b00, 0, 0, 2);
    doClear();
    checkAll("clr", 0, 0, 2'b00, 2'b00, 0, 0, 0);

    // Wrong data at the pass address
    doArm();
    applyStimulus(2'b01, 100, 6, 0, 0); tick();
    checkAll("wrong_data", 1, 0, 2'b10, 2'b00, 100, 6, 0);
    doClear();

    // Failing channel beats a same-cycle pass
    doArm();
    applyStimulus(2'b11, 100, 7, 104, 1); tick();
    checkAll("fail_beats_pass", 1, 0, 2'b01, 2'b01, 104, 1, 0);
    doClear();

    // Per-channel counting, then lowest failing index wins
    doArm();
    applyStimulus(2'b11, 96, 1, 96, 2); tick();
    checkOutput("cnt_two_ch", 32'(store_count), 2);
    applyStimulus(2'b11, 99, 4, 100, 6); tick();
    checkAll("lowest_fail", 1, 0, 2'b01, 2'b00, 99, 4, 2);
    doClear();

    // Legal store counted alongside a fail
    doArm();
    applyStimulus(2'b11, 96, 1, 200, 9); tick();
    checkAll("legal_with_fail", 1, 0, 2'b01, 2'b01, 200, 9, 1);
    doClear();

    // clr has priority over arm
    idle();
    clr = 1'b1; arm = 1'b1; tick();
    clr = 1'b0; arm = 1'b0;
    applyStimulus(2'b01, 100, 7, 0, 0); tick();
    checkAll("clr_over_arm", 0, 0, 2'b00, 2'b00, 0, 0, 0);
    idle();

    // Idle run: expires on the 10th edge after arm only when timeout is built in
    doArm();
    for (int i = 0; i < 9; i++) tick();
    checkOutput("pre_timeout.done", 32'(done), 0);
    tick();
`ifdef MEM_WRITE_CHECKER_TIMEOUT_EN
    checkAll("timeout", 1, 0, 2'b11, 2'b00, 0, 0, 0);
`else
    checkAll("no_timeout", 0, 0, 2'b00, 2'b00, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("no_timeout_late.done", 32'(done), 0);
`endif
    doClear();

    // Pass on the 10th RUN edge wins over timeout
    doArm();
    for (int i = 0; i < 9; i++) tick();
    applyStimulus(2'b01, 100, 7, 0, 0); tick();
    checkAll("pass_at_limit", 1, 1, 2'b00, 2'b00, 0, 0, 0);
    doClear();

    // Asynchronous reset mid-run
    doArm();
    applyStimulus(2'b01, 96, 1, 0, 0); tick();
    idle(); tick();
    checkOutput("pre_reset.count", 32'(store_count), 1);
    #2 reset = 1'b0;
    #1;
    checkAll("async_reset", 0, 0, 2'b00, 2'b00, 0, 0, 0);
    #1 reset = 1'b1;
    applyStimulus(2'b01, 100, 7, 0, 0); tick();
    checkAll("idle_after_reset", 0, 0, 2'b00, 2'b00, 0, 0, 0);
    idle();
    doArm();
    applyStimulus(2'b01, 100, 7, 0, 0); tick();
    checkOutput("rearm_pass", 32'(pass), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
